bus_xfer_sequencer: RTL and testbench

//   Sequences register-to-register transfers over the shared 16-bit bus. Queues
//   (src,dst) transfer commands and drives one-hot per-register enable (bus drive)
//   and latch (capture) strobes so that at most one register drives the bus at any

---
 rtl/bus_xfer_pkg.sv | 26 ++
 rtl/bus_xfer_fifo.sv | 56 +++++
 rtl/bus_xfer_sequencer.sv | 154 +++++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_xfer_pkg.sv
// Shared definitions for the bus transfer sequencer: FSM state encoding and
// default geometry of the register bus.
package bus_xfer_pkg;

  localparam int DEF_NUM_REGS   = 4;
  localparam int DEF_IDX_W      = 2;
  localparam int DEF_FIFO_DEPTH = 4;

  // IDLE waits for work, DRIVE opens the source, LATCH strobes the
  // destination, GAP is the mandatory dead cycle between bus drivers.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    LATCH = 2'd2,
    GAP   = 2'd3
  } xfer_state_e;

  // Command record at the default index width. The sequencer declares its
  // own copy sized by its IDX_W parameter, since packages cannot be
  // parameterised.
  typedef struct packed {
    logic [DEF_IDX_W-1:0] src;
    logic [DEF_IDX_W-1:0] dst;
  } xfer_cmd_t;

endpackage

// File: rtl/bus_xfer_fifo.sv
// Small synchronous FIFO holding queued transfer commands. The head entry is
// presented combinationally on rdata. Pushes when full and pops when empty
// are ignored.
module bus_xfer_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Sequences register-to-register transfers over the shared bus: queues
// (src,dst) commands and drives one-hot enable/latch strobes with a dead
// cycle between successive bus drivers.
// Optional feature macro BUS_XFER_CHECK_EN: when defined, commands with
// src==dst or an out-of-range index are dropped and flagged on err.
module bus_xfer_sequencer
  import bus_xfer_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [IDX_W-1:0]    req_src,
  input  logic [IDX_W-1:0]    req_dst,
  output logic                req_ready,
  output logic [NUM_REGS-1:0] enable,
  output logic [NUM_REGS-1:0] latch,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [IDX_W-1:0] src;
    logic [IDX_W-1:0] dst;
  } cmd_t;

  cmd_t            req_cmd;
  cmd_t            head_cmd;
  cmd_t            cmd_q;
  xfer_state_e     state;
  logic            full;
  logic            empty;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            accept;
  logic            cmd_ok;
  logic            reject;
  logic            push;
  logic            pop;
  logic            queue_busy_nxt;
  logic [NUM_REGS-1:0] src_oh;
  logic [NUM_REGS-1:0] dst_oh;

  assign req_cmd   = '{src: req_src, dst: req_dst};
  assign req_ready = !full;
  assign accept    = req_valid && !full;

`ifdef BUS_XFER_CHECK_EN
  // Reject self-transfers and indices that address no register.
  always_comb begin
    cmd_ok = (req_src != req_dst)
          && ({1'b0, req_src} < (IDX_W+1)'(NUM_REGS))
          && ({1'b0, req_dst} < (IDX_W+1)'(NUM_REGS));
  end
  assign reject = accept && !cmd_ok;
`else
  assign cmd_ok = 1'b1;
  assign reject = 1'b0;
`endif

  assign push = accept && cmd_ok;
  assign pop  = !empty && ((state == IDLE) || (state == GAP));

  // Queue occupancy after this edge, so busy can be registered alongside the FSM.
  assign count_nxt      = count + CW'(push) - CW'(pop);
  assign queue_busy_nxt = (count_nxt != '0);

  bus_xfer_fifo #(
    .WIDTH ($bits(cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (req_cmd),
    .pop   (pop),
    .rdata (head_cmd),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // Decode the active command into strobes; out-of-range indices give zero.
  always_comb begin
    src_oh = '0;
    dst_oh = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      src_oh[i] = (cmd_q.src == IDX_W'(i));
      dst_oh[i] = (cmd_q.dst == IDX_W'(i));
    end
  end

  // Transfer FSM with registered strobes; each state's action lands at the edge leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cmd_q  <= '0;
      enable <= '0;
      latch  <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= reject;
      case (state)
        IDLE: begin
          if (!empty) begin
            cmd_q <= head_cmd;
            state <= DRIVE;
            busy  <= 1'b1;
          end else begin
            busy  <= queue_busy_nxt;
          end
        end
        DRIVE: begin
          enable <= src_oh;
          state  <= LATCH;
          busy   <= 1'b1;
        end
        LATCH: begin
          latch <= dst_oh;
          state <= GAP;
          busy  <= 1'b1;
        end
        GAP: begin
          enable <= '0;
          latch  <= '0;
          done   <= 1'b1;
          if (!empty) begin
            cmd_q <= head_cmd;
            state <= DRIVE;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= queue_busy_nxt;
          end
        end
        default: begin
          enable <= '0;
          latch  <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed testbench for bus_xfer_sequencer. Built with IDX_W=3 so that an
// out-of-range register index can be offered.
module tb_bus_xfer_sequencer;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic [2:0] req_src;
  logic [2:0] req_dst;
  logic       req_ready;
  logic [3:0] enable;
  logic [3:0] latch;
  logic       busy;
  logic       done;
  logic       err;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int done_cnt = 0;

  typedef struct {
    logic [3:0] en;
    logic [3:0] lat;
    int         cyc;
  } evt_t;

  typedef struct {
    logic       valid;
    logic [2:0] src;
    logic [2:0] dst;
    logic [3:0] en;
    logic [3:0] lat;
    logic       done;
    logic       busy;
    logic       ready;
  } vec_t;

  evt_t       events[$];
  int         exp_src[$];
  int         exp_dst[$];
  logic [3:0] prev_en;
  vec_t       tbl[6];

  bus_xfer_sequencer #(
    .NUM_REGS   (4),
    .IDX_W      (3),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_src   (req_src),
    .req_dst   (req_dst),
    .req_ready (req_ready),
    .enable    (enable),
    .latch     (latch),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] oh(input int i);
    logic [3:0] o;
    o = '0;
    if (i >= 0 && i < 4) o[i] = 1'b1;
    return o;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input int s, input int d);
    req_valid = v;
    req_src   = 3'(s);
    req_dst   = 3'(d);
    @(posedge clk);
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0);
  endtask

  task automatic waitDone(input string name, input int target, input int budget);
    int k;
    k = 0;
    req_valid = 1'b0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_cnt < target) checkOutput({name, "_timeout"}, 32'(done_cnt), 32'(target));
  endtask

  task automatic checkEvents(input string name, input bit spacing);
    checkOutput({name, "_count"}, 32'(events.size()), 32'(exp_src.size()));
    for (int i = 0; i < exp_src.size(); i++) begin
      if (i < events.size()) begin
        checkOutput($sformatf("%s_en%0d", name, i), 32'(events[i].en), 32'(oh(exp_src[i])));
        checkOutput($sformatf("%s_lat%0d", name, i), 32'(events[i].lat), 32'(oh(exp_dst[i])));
        if (spacing && i > 0)
          checkOutput($sformatf("%s_gap%0d", name, i), 32'(events[i].cyc - events[i-1].cyc), 32'd3);
      end
    end
    events.delete();
    exp_src.delete();
    exp_dst.delete();
  endtask

  // Per-cycle monitor: strobe invariants, latch event log and done counting.
  always @(negedge clk) begin
    cycle++;
    if (!rst_n) begin
      prev_en = '0;
    end else begin
      checkOutput("onehot_en", 32'($countones(enable) <= 1), 32'd1);
      checkOutput("onehot_lat", 32'($countones(latch) <= 1), 32'd1);
      if (enable != 4'b0 && prev_en != 4'b0) checkOutput("en_src_hold", 32'(enable), 32'(prev_en));
      if (latch != 4'b0) events.push_back('{enable, latch, cycle});
      if (done) done_cnt++;
      prev_en = enable;
    end
  end

  initial begin
    int base;
    int k;

    tbl[0] = '{1'b1, 3'd0, 3'd1, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 3'd0, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 3'd0, 3'd0, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 3'd0, 3'd0, 4'b0001, 4'b0010, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 3'd0, 3'd0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 3'd0, 3'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};

    // Reset held with a command offered: nothing may be accepted or strobed.
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_src   = 3'd0;
    req_dst   = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_en", 32'(enable), 32'h0);
      checkOutput("rst_lat", 32'(latch), 32'h0);
      checkOutput("rst_ready", 32'(req_ready), 32'h1);
      checkOutput("rst_done", 32'(done), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
    end
    req_valid = 1'b0;
    #2 rst_n = 1'b1;
    idleCycles(2);
    checkOutput("post_rst_busy", 32'(busy), 32'h0);
    checkOutput("post_rst_en", 32'(enable), 32'h0);

    // Single transfer 0->1, cycle by cycle from the table.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i].valid, int'(tbl[i].src), int'(tbl[i].dst));
      checkOutput($sformatf("single_v%0d_en", i), 32'(enable), 32'(tbl[i].en));
      checkOutput($sformatf("single_v%0d_lat", i), 32'(latch), 32'(tbl[i].lat));
      checkOutput($sformatf("single_v%0d_done", i), 32'(done), 32'(tbl[i].done));
      checkOutput($sformatf("single_v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      checkOutput($sformatf("single_v%0d_ready", i), 32'(req_ready), 32'(tbl[i].ready));
      checkOutput($sformatf("single_v%0d_err", i), 32'(err), 32'h0);
    end
    events.delete();

    // Six back-to-back commands: the queue fills, then drains in order.
    base = done_cnt;
    for (int i = 0; i < 6; i++) begin
      int s;
      int d;
      s = (i < 4) ? i : i - 4;
      d = (i < 4) ? (i + 1) % 4 : i - 2;
      checkOutput($sformatf("b2b_ready_before%0d", i), 32'(req_ready), 32'h1);
      applyStimulus(1'b1, s, d);
      exp_src.push_back(s);
      exp_dst.push_back(d);
    end
    checkOutput("b2b_full_e5", 32'(req_ready), 32'h0);
    idleCycles(1);
    checkOutput("b2b_full_e6", 32'(req_ready), 32'h0);
    idleCycles(1);
    checkOutput("b2b_free_e7", 32'(req_ready), 32'h1);
    waitDone("b2b", base + 6, 60);
    idleCycles(2);
    checkOutput("b2b_done_count", 32'(done_cnt - base), 32'd6);
    checkOutput("b2b_idle_busy", 32'(busy), 32'h0);
    checkEvents("b2b", 1'b1);

    // Reset dropped while 2->3 is latching, with 3->0 still queued.
    base = done_cnt;
    applyStimulus(1'b1, 0, 1);
    applyStimulus(1'b1, 1, 2);
    applyStimulus(1'b1, 2, 3);
    applyStimulus(1'b1, 3, 0);
    req_valid = 1'b0;
    k = 0;
    while (latch != 4'b1000 && k < 30) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("abort_reach_latch", 32'(latch), 32'h8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_en", 32'(enable), 32'h0);
    checkOutput("abort_lat", 32'(latch), 32'h0);
    checkOutput("abort_done", 32'(done), 32'h0);
    checkOutput("abort_busy", 32'(busy), 32'h0);
    checkOutput("abort_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    idleCycles(12);
    checkOutput("abort_done_count", 32'(done_cnt - base), 32'd2);
    checkOutput("abort_queue_empty", 32'(busy), 32'h0);
    exp_src = '{0, 1};
    exp_dst = '{1, 2};
    checkEvents("abort", 1'b1);

    // Self-transfer 2->2 and out-of-range source 5.
    base = done_cnt;
    applyStimulus(1'b1, 2, 2);
    checkOutput("self_ready", 32'(req_ready), 32'h1);
`ifdef BUS_XFER_CHECK_EN
    checkOutput("self_err", 32'(err), 32'h1);
`else
    checkOutput("self_err", 32'(err), 32'h0);
    exp_src.push_back(2);
    exp_dst.push_back(2);
`endif
    applyStimulus(1'b0, 0, 0);
    checkOutput("self_err_clear", 32'(err), 32'h0);
    idleCycles(6);
    applyStimulus(1'b1, 5, 1);
`ifdef BUS_XFER_CHECK_EN
    checkOutput("range_err", 32'(err), 32'h1);
    applyStimulus(1'b0, 0, 0);
    idleCycles(6);
    checkOutput("check_done_count", 32'(done_cnt - base), 32'd0);
`else
    checkOutput("range_err", 32'(err), 32'h0);
    exp_src.push_back(5);
    exp_dst.push_back(1);
    waitDone("range", base + 2, 20);
    idleCycles(2);
    checkOutput("check_done_count", 32'(done_cnt - base), 32'd2);
`endif
    checkEvents("check", 1'b0);

    // Steady state: pushes land on the same edge as pops, queue stays at one entry.
    base = done_cnt;
    for (int i = 0; i < 8; i++) begin
      if (i >= 2) idleCycles(2);
      applyStimulus(1'b1, i % 4, (i + 2) % 4);
      checkOutput($sformatf("steady_ready%0d", i), 32'(req_ready), 32'h1);
      exp_src.push_back(i % 4);
      exp_dst.push_back((i + 2) % 4);
    end
    waitDone("steady", base + 8, 40);
    idleCycles(2);
    checkOutput("steady_done_count", 32'(done_cnt - base), 32'd8);
    checkEvents("steady", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
